// File: rtl/llc_input_scheduler_pkg.sv
// Shared LLC scheduler types: set/tag widths, state encoding and one-hot source slots.
// Slot order is also the arbitration priority, with index 0 the highest.
package llc_input_scheduler_pkg;

    localparam int LLC_SET_BITS = 8;
    localparam int LLC_TAG_BITS = 16;

    typedef logic [LLC_SET_BITS-1:0] llc_set_t;
    typedef logic [LLC_TAG_BITS-1:0] llc_tag_t;

    typedef enum logic [1:0] {
        ST_ARB   = 2'd0,
        ST_ISSUE = 2'd1,
        ST_PROC  = 2'd2
    } llc_sched_state_t;

    localparam int N_SRC         = 7;
    localparam int SRC_RST       = 0;
    localparam int SRC_FLUSH     = 1;
    localparam int SRC_RSP       = 2;
    localparam int SRC_REQ       = 3;
    localparam int SRC_DMA_READ  = 4;
    localparam int SRC_DMA_WRITE = 5;
    localparam int SRC_DMA_REQ   = 6;

endpackage

// File: rtl/llc_input_scheduler_prio_enc.sv
// Fixed-priority one-hot encoder: lowest set request index wins.
// Purely combinational, zero latency, no flow control.
module llc_sched_prio_enc
    import llc_input_scheduler_pkg::*;
(
    input  logic [N_SRC-1:0] req_i,
    output logic [N_SRC-1:0] gnt_o
);

    always_comb begin
        gnt_o = '0;
        for (int i = N_SRC - 1; i >= 0; i--) begin
            if (req_i[i]) begin
                gnt_o    = '0;
                gnt_o[i] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/llc_input_scheduler.sv
// LLC set-read front-end sequencer: ARB -> ISSUE (1 cycle, selects + ready) -> PROC until process_done.
// Three cycles minimum per transaction; inputs are popped only by the one-cycle ready in ISSUE.
module llc_input_scheduler
    import llc_input_scheduler_pkg::*;
#(
    parameter int SET_BITS = LLC_SET_BITS,
    parameter int TAG_BITS = LLC_TAG_BITS
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                rsp_in_valid,
    input  logic                req_in_valid,
    input  logic                dma_req_in_valid,
    output logic                rsp_in_ready,
    output logic                req_in_ready,
    output logic                dma_req_in_ready,
    input  logic                rst_req,
    input  logic                flush_req,
    input  logic                incr_rst_flush_stalled_set,
    input  logic                clr_rst_stall,
    input  logic                clr_flush_stall,
    input  logic                clr_req_stall,
    input  logic                req_stall_set,
    input  logic [TAG_BITS-1:0] req_stall_tag,
    input  logic [SET_BITS-1:0] req_stall_idx,
    input  logic                dma_read_stall_set,
    input  logic                dma_write_stall_set,
    input  logic                dma_done,
    input  logic                process_done,
    output logic                is_rsp_to_get,
    output logic                is_req_to_get,
    output logic                is_dma_req_to_get,
    output logic                is_dma_read_to_resume,
    output logic                is_dma_write_to_resume,
    output logic                is_flush_to_resume,
    output logic                is_rst_to_resume,
    output logic                rd_set_en,
    output logic [SET_BITS-1:0] rst_flush_stalled_set,
    output logic [TAG_BITS-1:0] req_in_stalled_tag,
    output logic [SET_BITS-1:0] req_in_stalled_set,
    output logic                req_stall,
    output logic                rst_stall,
    output logic                flush_stall,
    output logic                dma_read_pending,
    output logic                dma_write_pending,
    output logic                busy
);

    llc_sched_state_t    state_q;
    logic [N_SRC-1:0]    sel_q, elig, gnt;
    logic                rd_set_en_q;

    logic                rst_stall_q, rst_stall_d, flush_stall_q, flush_stall_d;
    logic [SET_BITS-1:0] walk_set_q, walk_set_d;
    logic                req_stall_q, req_stall_d;
    logic [TAG_BITS-1:0] stall_tag_q, stall_tag_d;
    logic [SET_BITS-1:0] stall_set_q, stall_set_d;
    logic                dma_rd_q, dma_rd_d, dma_wr_q, dma_wr_d;

    logic in_issue, in_proc, walk_active;

    assign in_issue    = (state_q == ST_ISSUE);
    assign in_proc     = (state_q == ST_PROC);
    assign walk_active = rst_stall_q | flush_stall_q;

    // A running walk locks out everything except its own resume.
    always_comb begin
        elig                = '0;
        elig[SRC_RST]       = rst_stall_q;
        elig[SRC_FLUSH]     = flush_stall_q;
        elig[SRC_RSP]       = rsp_in_valid & ~walk_active;
        elig[SRC_REQ]       = req_in_valid & ~req_stall_q & ~walk_active;
        elig[SRC_DMA_READ]  = dma_rd_q & ~walk_active;
        elig[SRC_DMA_WRITE] = dma_wr_q & ~walk_active;
        elig[SRC_DMA_REQ]   = dma_req_in_valid & ~dma_rd_q & ~dma_wr_q & ~walk_active;
    end

    llc_sched_prio_enc u_prio_enc (
        .req_i (elig),
        .gnt_o (gnt)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_ARB;
            sel_q       <= '0;
            rd_set_en_q <= 1'b0;
        end else begin
            case (state_q)
                ST_ARB: begin
                    if (|gnt) begin
                        sel_q       <= gnt;
                        rd_set_en_q <= 1'b1;
                        state_q     <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    sel_q       <= '0;
                    rd_set_en_q <= 1'b0;
                    state_q     <= ST_PROC;
                end
                ST_PROC: begin
                    if (process_done) state_q <= ST_ARB;
                end
                default: begin
                    sel_q       <= '0;
                    rd_set_en_q <= 1'b0;
                    state_q     <= ST_ARB;
                end
            endcase
        end
    end

    // Clear beats a same-cycle increment; a new walk starts only from idle, rst over flush.
    always_comb begin
        rst_stall_d   = rst_stall_q;
        flush_stall_d = flush_stall_q;
        walk_set_d    = walk_set_q;
        if (in_issue && incr_rst_flush_stalled_set)
            walk_set_d = walk_set_q + {{(SET_BITS-1){1'b0}}, 1'b1};
        if (in_issue && (clr_rst_stall || clr_flush_stall)) begin
            rst_stall_d   = 1'b0;
            flush_stall_d = 1'b0;
            walk_set_d    = '0;
        end
        if (!walk_active && rst_req) begin
            rst_stall_d = 1'b1;
            walk_set_d  = '0;
        end else if (!walk_active && flush_req) begin
            flush_stall_d = 1'b1;
            walk_set_d    = '0;
        end
    end

    always_comb begin
        req_stall_d = req_stall_q;
        stall_tag_d = stall_tag_q;
        stall_set_d = stall_set_q;
        dma_rd_d    = dma_rd_q;
        dma_wr_d    = dma_wr_q;
        if (in_issue && clr_req_stall) req_stall_d = 1'b0;
        if (in_proc && req_stall_set) begin
            req_stall_d = 1'b1;
            stall_tag_d = req_stall_tag;
            stall_set_d = req_stall_idx;
        end
        if (in_proc) begin
            if (dma_read_stall_set)  dma_rd_d = 1'b1;
            if (dma_write_stall_set) dma_wr_d = 1'b1;
            if (dma_done) begin
                dma_rd_d = 1'b0;
                dma_wr_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rst_stall_q   <= 1'b0;
            flush_stall_q <= 1'b0;
            walk_set_q    <= '0;
            req_stall_q   <= 1'b0;
            stall_tag_q   <= '0;
            stall_set_q   <= '0;
            dma_rd_q      <= 1'b0;
            dma_wr_q      <= 1'b0;
        end else begin
            rst_stall_q   <= rst_stall_d;
            flush_stall_q <= flush_stall_d;
            walk_set_q    <= walk_set_d;
            req_stall_q   <= req_stall_d;
            stall_tag_q   <= stall_tag_d;
            stall_set_q   <= stall_set_d;
            dma_rd_q      <= dma_rd_d;
            dma_wr_q      <= dma_wr_d;
        end
    end

    assign is_rst_to_resume       = sel_q[SRC_RST];
    assign is_flush_to_resume     = sel_q[SRC_FLUSH];
    assign is_rsp_to_get          = sel_q[SRC_RSP];
    assign is_req_to_get          = sel_q[SRC_REQ];
    assign is_dma_read_to_resume  = sel_q[SRC_DMA_READ];
    assign is_dma_write_to_resume = sel_q[SRC_DMA_WRITE];
    assign is_dma_req_to_get      = sel_q[SRC_DMA_REQ];
    assign rsp_in_ready           = sel_q[SRC_RSP];
    assign req_in_ready           = sel_q[SRC_REQ];
    assign dma_req_in_ready       = sel_q[SRC_DMA_REQ];
    assign rd_set_en              = rd_set_en_q;
    assign rst_flush_stalled_set  = walk_set_q;
    assign req_in_stalled_tag     = stall_tag_q;
    assign req_in_stalled_set     = stall_set_q;
    assign req_stall              = req_stall_q;
    assign rst_stall              = rst_stall_q;
    assign flush_stall            = flush_stall_q;
    assign dma_read_pending       = dma_rd_q;
    assign dma_write_pending      = dma_wr_q;
    assign busy                   = (state_q != ST_ARB);

endmodule

// File: tb/tb_llc_input_scheduler.sv
// Directed bench for llc_input_scheduler: grant order, walk counter, req/DMA stalls, async reset.
module tb_llc_input_scheduler;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;
    logic rsp_in_valid, req_in_valid, dma_req_in_valid;
    logic rsp_in_ready, req_in_ready, dma_req_in_ready;
    logic rst_req, flush_req;
    logic incr_rst_flush_stalled_set, clr_rst_stall, clr_flush_stall, clr_req_stall;
    logic req_stall_set;
    logic [15:0] req_stall_tag;
    logic [7:0]  req_stall_idx;
    logic dma_read_stall_set, dma_write_stall_set, dma_done, process_done;
    logic is_rsp_to_get, is_req_to_get, is_dma_req_to_get, is_dma_read_to_resume;
    logic is_dma_write_to_resume, is_flush_to_resume, is_rst_to_resume, rd_set_en;
    logic [7:0]  rst_flush_stalled_set;
    logic [15:0] req_in_stalled_tag;
    logic [7:0]  req_in_stalled_set;
    logic req_stall, rst_stall, flush_stall, dma_read_pending, dma_write_pending, busy;

    logic [6:0] sel_vec;
    logic [6:0] g;
    assign sel_vec = {is_dma_req_to_get, is_dma_write_to_resume, is_dma_read_to_resume,
                      is_req_to_get, is_rsp_to_get, is_flush_to_resume, is_rst_to_resume};

    llc_input_scheduler dut (
        .clk(clk), .rst(rst),
        .rsp_in_valid(rsp_in_valid), .req_in_valid(req_in_valid), .dma_req_in_valid(dma_req_in_valid),
        .rsp_in_ready(rsp_in_ready), .req_in_ready(req_in_ready), .dma_req_in_ready(dma_req_in_ready),
        .rst_req(rst_req), .flush_req(flush_req),
        .incr_rst_flush_stalled_set(incr_rst_flush_stalled_set),
        .clr_rst_stall(clr_rst_stall), .clr_flush_stall(clr_flush_stall), .clr_req_stall(clr_req_stall),
        .req_stall_set(req_stall_set), .req_stall_tag(req_stall_tag), .req_stall_idx(req_stall_idx),
        .dma_read_stall_set(dma_read_stall_set), .dma_write_stall_set(dma_write_stall_set),
        .dma_done(dma_done), .process_done(process_done),
        .is_rsp_to_get(is_rsp_to_get), .is_req_to_get(is_req_to_get),
        .is_dma_req_to_get(is_dma_req_to_get), .is_dma_read_to_resume(is_dma_read_to_resume),
        .is_dma_write_to_resume(is_dma_write_to_resume), .is_flush_to_resume(is_flush_to_resume),
        .is_rst_to_resume(is_rst_to_resume), .rd_set_en(rd_set_en),
        .rst_flush_stalled_set(rst_flush_stalled_set),
        .req_in_stalled_tag(req_in_stalled_tag), .req_in_stalled_set(req_in_stalled_set),
        .req_stall(req_stall), .rst_stall(rst_stall), .flush_stall(flush_stall),
        .dma_read_pending(dma_read_pending), .dma_write_pending(dma_write_pending), .busy(busy)
    );

    int nvec = 0;
    int nmis = 0;

    task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nmis++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Bounded wait for the ISSUE cycle; returns 0 on timeout so the caller's check fails.
    task automatic wait_grant(output logic [6:0] gv);
        gv = '0;
        for (int k = 0; k < 20; k++) begin
            tick();
            if (sel_vec != 7'd0) begin
                gv = sel_vec;
                break;
            end
        end
    endtask

    // Called in ISSUE: advance into PROC and finish the transaction in its first cycle.
    task automatic finish_txn;
        tick();
        process_done = 1'b1;
        tick();
        process_done = 1'b0;
    endtask

    initial begin
        rst = 1'b0;
        {rsp_in_valid, req_in_valid, dma_req_in_valid, rst_req, flush_req} = '0;
        {incr_rst_flush_stalled_set, clr_rst_stall, clr_flush_stall, clr_req_stall} = '0;
        {req_stall_set, dma_read_stall_set, dma_write_stall_set, dma_done, process_done} = '0;
        req_stall_tag = '0;
        req_stall_idx = '0;
        tick();
        tick();
        check_vec("reset_sel", 32'(sel_vec), 32'h0);
        check_vec("reset_flags", 32'({req_stall, rst_stall, flush_stall, dma_read_pending,
                                      dma_write_pending, busy, rd_set_en}), 32'h0);
        check_vec("reset_cnt", 32'(rst_flush_stalled_set), 32'h0);
        rst = 1'b1;

        // rsp beats req; req follows after process_done
        rsp_in_valid = 1'b1;
        req_in_valid = 1'b1;
        wait_grant(g);
        check_vec("t1_rsp_sel", 32'(g), 32'h04);
        check_vec("t1_rsp_rdy", 32'({rsp_in_ready, req_in_ready, rd_set_en, busy}), 32'hB);
        rsp_in_valid = 1'b0;
        tick();
        check_vec("t1_proc", 32'({rsp_in_ready, rd_set_en, busy}), 32'h1);
        process_done = 1'b1;
        tick();
        process_done = 1'b0;
        check_vec("t1_idle", 32'(busy), 32'h0);
        wait_grant(g);
        check_vec("t1_req_sel", 32'(g), 32'h08);
        check_vec("t1_req_rdy", 32'(req_in_ready), 32'h1);
        req_in_valid = 1'b0;
        finish_txn();

        // full reset walk over 256 sets
        rst_req = 1'b1;
        tick();
        rst_req = 1'b0;
        check_vec("walk_start", 32'({rst_stall, flush_stall}), 32'h2);
        for (int i = 0; i < 256; i++) begin
            wait_grant(g);
            check_vec("walk_sel", 32'(g), 32'h01);
            check_vec("walk_cnt", 32'(rst_flush_stalled_set), 32'(i));
            incr_rst_flush_stalled_set = 1'b1;
            clr_rst_stall = (i == 255);
            tick();
            incr_rst_flush_stalled_set = 1'b0;
            clr_rst_stall = 1'b0;
            process_done = 1'b1;
            tick();
            process_done = 1'b0;
        end
        check_vec("walk_end", 32'({rst_stall, rst_flush_stalled_set}), 32'h0);
        tick();
        check_vec("walk_nogrant", 32'({sel_vec, busy}), 32'h0);

        // request stall capture, blocking and release via a rsp grant
        req_in_valid = 1'b1;
        wait_grant(g);
        check_vec("rs_req_sel", 32'(g), 32'h08);
        req_in_valid = 1'b0;
        tick();
        req_stall_set = 1'b1;
        req_stall_tag = 16'h001A;
        req_stall_idx = 8'h05;
        process_done = 1'b1;
        tick();
        req_stall_set = 1'b0;
        process_done = 1'b0;
        check_vec("rs_flag", 32'(req_stall), 32'h1);
        check_vec("rs_tag", 32'(req_in_stalled_tag), 32'h1A);
        check_vec("rs_idx", 32'(req_in_stalled_set), 32'h05);
        req_in_valid = 1'b1;
        tick();
        tick();
        check_vec("rs_blocked", 32'({sel_vec, req_in_ready, busy}), 32'h0);
        rsp_in_valid = 1'b1;
        wait_grant(g);
        check_vec("rs_rsp_sel", 32'(g), 32'h04);
        rsp_in_valid = 1'b0;
        clr_req_stall = 1'b1;
        tick();
        clr_req_stall = 1'b0;
        check_vec("rs_cleared", 32'(req_stall), 32'h0);
        process_done = 1'b1;
        tick();
        process_done = 1'b0;
        wait_grant(g);
        check_vec("rs_req_again", 32'(g), 32'h08);
        req_in_valid = 1'b0;
        finish_txn();

        // DMA read resume twice, new DMA req held off until dma_done
        dma_req_in_valid = 1'b1;
        wait_grant(g);
        check_vec("dma_req_sel", 32'(g), 32'h40);
        check_vec("dma_req_rdy", 32'(dma_req_in_ready), 32'h1);
        tick();
        dma_read_stall_set = 1'b1;
        process_done = 1'b1;
        tick();
        dma_read_stall_set = 1'b0;
        process_done = 1'b0;
        check_vec("dma_rd_pend", 32'({dma_read_pending, dma_write_pending}), 32'h2);
        wait_grant(g);
        check_vec("dma_resume1", 32'(g), 32'h10);
        check_vec("dma_blk_rdy", 32'(dma_req_in_ready), 32'h0);
        tick();
        dma_read_stall_set = 1'b1;
        process_done = 1'b1;
        tick();
        dma_read_stall_set = 1'b0;
        process_done = 1'b0;
        wait_grant(g);
        check_vec("dma_resume2", 32'(g), 32'h10);
        tick();
        dma_done = 1'b1;
        dma_read_stall_set = 1'b1;
        process_done = 1'b1;
        tick();
        dma_done = 1'b0;
        dma_read_stall_set = 1'b0;
        process_done = 1'b0;
        check_vec("dma_done_clr", 32'({dma_read_pending, dma_write_pending}), 32'h0);
        wait_grant(g);
        check_vec("dma_req2_sel", 32'(g), 32'h40);
        dma_req_in_valid = 1'b0;
        finish_txn();

        // simultaneous starts: rst wins; flush during walk ignored
        rst_req = 1'b1;
        flush_req = 1'b1;
        tick();
        rst_req = 1'b0;
        flush_req = 1'b0;
        check_vec("both_start", 32'({rst_stall, flush_stall}), 32'h2);
        wait_grant(g);
        check_vec("both_sel", 32'(g), 32'h01);
        incr_rst_flush_stalled_set = 1'b1;
        tick();
        incr_rst_flush_stalled_set = 1'b0;
        flush_req = 1'b1;
        process_done = 1'b1;
        tick();
        flush_req = 1'b0;
        process_done = 1'b0;
        check_vec("flush_ignored", 32'({rst_stall, flush_stall}), 32'h2);
        check_vec("walk_cnt1", 32'(rst_flush_stalled_set), 32'h1);
        wait_grant(g);
        incr_rst_flush_stalled_set = 1'b1;
        clr_rst_stall = 1'b1;
        tick();
        incr_rst_flush_stalled_set = 1'b0;
        clr_rst_stall = 1'b0;
        check_vec("clr_incr", 32'({rst_stall, flush_stall, rst_flush_stalled_set}), 32'h0);
        process_done = 1'b1;
        tick();
        process_done = 1'b0;

        // flush walk alone, ended by clr_flush_stall
        flush_req = 1'b1;
        tick();
        flush_req = 1'b0;
        check_vec("flush_start", 32'({rst_stall, flush_stall}), 32'h1);
        rsp_in_valid = 1'b1;
        wait_grant(g);
        check_vec("flush_sel", 32'(g), 32'h02);
        clr_flush_stall = 1'b1;
        tick();
        clr_flush_stall = 1'b0;
        check_vec("flush_clr", 32'(flush_stall), 32'h0);
        process_done = 1'b1;
        tick();
        process_done = 1'b0;

        // async reset while in ISSUE
        wait_grant(g);
        check_vec("arst_pre", 32'(g), 32'h04);
        #2 rst = 1'b0;
        #1;
        check_vec("arst_outs", 32'({sel_vec, rsp_in_ready, rd_set_en, busy}), 32'h0);
        tick();
        check_vec("arst_hold", 32'({rsp_in_ready, busy}), 32'h0);
        rsp_in_valid = 1'b0;
        rst = 1'b1;
        tick();
        check_vec("arst_after", 32'({sel_vec, busy}), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
